// File: rtl/entrada_botoes_pkg.sv
// Shared constants and FSM state encodings for the button input stage.
// The game datapath debug decoders reuse the same state encodings.
package entrada_botoes_pkg;

    localparam int N_BOTOES_PAD        = 4;
    localparam int DEBOUNCE_CICLOS_PAD = 5;
    localparam int CW_PAD              = 4;

    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        FILTRA       = 3'd1,
        EMITE        = 3'd2,
        ESPERA_SOLTA = 3'd3
    } estado_t;

endpackage

// File: rtl/entrada_botoes_sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous button levels.
// Synchronous active-high reset clears both stages.
module sincronizador_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/entrada_botoes.sv
// Button input stage: synchronise, debounce and emit one clean play per press.
// Outputs a 1-cycle tem_jogada pulse plus a held play code.
import entrada_botoes_pkg::*;

module entrada_botoes #(
    parameter int N_BOTOES        = N_BOTOES_PAD,
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PAD,
    parameter int CW              = CW_PAD
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                habilita,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                tem_jogada,
    output logic [N_BOTOES-1:0] jogada,
    output logic                multipla,
    output logic [2:0]          db_estado
);

    localparam logic [CW-1:0]       CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [CW-1:0]       CNT_UM  = CW'(1);
    localparam logic [N_BOTOES-1:0] COD_UM  = N_BOTOES'(1);

    logic [N_BOTOES-1:0] w_s;
    logic                w_onehot;

    estado_t             r_estado;
    logic [CW-1:0]       r_cnt;
    logic [N_BOTOES-1:0] r_cand;
    logic [N_BOTOES-1:0] r_jogada;
    logic                r_multipla;
    logic                r_tem;
    logic                r_armado;

    sincronizador_2ff #(
        .WIDTH (N_BOTOES)
    ) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (w_s)
    );

    assign w_onehot = (r_cand != '0) &&
                      ((r_cand & (r_cand - COD_UM)) == '0);

    // r_armado blocks a button already held while disabled from
    // being taken as a play once habilita rises; it rearms on release.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= OCIOSO;
            r_cnt      <= '0;
            r_cand     <= '0;
            r_jogada   <= '0;
            r_multipla <= 1'b0;
            r_tem      <= 1'b0;
            r_armado   <= 1'b0;
        end else begin
            r_tem <= 1'b0;
            if (w_s == '0)
                r_armado <= 1'b1;
            else if (!habilita)
                r_armado <= 1'b0;

            case (r_estado)
                OCIOSO: begin
                    if (habilita && (w_s != '0) && r_armado) begin
                        r_cand   <= w_s;
                        r_cnt    <= '0;
                        r_estado <= FILTRA;
                    end
                end
                FILTRA: begin
                    if (!habilita) begin
                        r_cnt    <= '0;
                        r_estado <= ESPERA_SOLTA;
                    end else if (w_s != r_cand) begin
                        r_estado <= OCIOSO;
                    end else if (r_cnt == CNT_MAX) begin
                        r_jogada   <= r_cand;
                        r_multipla <= ~w_onehot;
                        r_tem      <= 1'b1;
                        r_estado   <= EMITE;
                    end else begin
                        r_cnt <= r_cnt + CNT_UM;
                    end
                end
                EMITE: begin
                    r_cnt    <= '0;
                    r_estado <= ESPERA_SOLTA;
                end
                ESPERA_SOLTA: begin
                    if (w_s != '0)
                        r_cnt <= '0;
                    else if (r_cnt == CNT_MAX)
                        r_estado <= OCIOSO;
                    else
                        r_cnt <= r_cnt + CNT_UM;
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign tem_jogada = r_tem;
    assign jogada     = r_jogada;
    assign multipla   = r_multipla;
    assign db_estado  = r_estado;

endmodule

// File: tb/tb_entrada_botoes.sv
// Scoreboard bench for entrada_botoes: expected plays queued at press time,
// checked against each tem_jogada pulse.
module tb_entrada_botoes;

    import entrada_botoes_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilita;
    logic [3:0] botoes;
    logic       tem_jogada;
    logic [3:0] jogada;
    logic       multipla;
    logic [2:0] db_estado;

    entrada_botoes dut (
        .clock      (clock),
        .reset      (reset),
        .habilita   (habilita),
        .botoes     (botoes),
        .tem_jogada (tem_jogada),
        .jogada     (jogada),
        .multipla   (multipla),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] cod;
        logic       mult;
        int         ciclo;
    } esp_t;

    esp_t fila[$];
    esp_t e_mon;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called right after botoes starts its stable hold.
    task automatic esperado(input logic [3:0] cod, input logic mult);
        esp_t e;
        e.cod   = cod;
        e.mult  = mult;
        e.ciclo = cyc + 8;
        fila.push_back(e);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (tem_jogada) begin
                if (fila.size() == 0) begin
                    chk("pulso_extra", 32'(tem_jogada), 0);
                end else begin
                    e_mon = fila.pop_front();
                    chk("pulso_ciclo", cyc, e_mon.ciclo);
                    chk("jogada", 32'(jogada), 32'(e_mon.cod));
                    chk("multipla", 32'(multipla), 32'(e_mon.mult));
                end
            end else if (fila.size() > 0 && cyc > fila[0].ciclo) begin
                chk("pulso_falta", 32'(tem_jogada), 1);
                void'(fila.pop_front());
            end
        end
    end

    int r;

    initial begin
        reset    = 1'b1;
        habilita = 1'b0;
        botoes   = 4'b0000;
        tick(1);
        chk("rst_jogada", 32'(jogada), 0);
        chk("rst_tem", 32'(tem_jogada), 0);
        chk("rst_mult", 32'(multipla), 0);
        chk("rst_estado", 32'(db_estado), 0);
        reset = 1'b0;

        // single clean press and release timing
        habilita = 1'b1;
        tick(2);
        botoes = 4'b0001;
        esperado(4'b0001, 1'b0);
        tick(10);
        chk("t2_espera", 32'(db_estado), 3);
        botoes = 4'b0000;
        r = cyc;
        tick(6);
        chk("t2_solta_ainda", 32'(db_estado), 3);
        tick(1);
        chk("t2_ocioso", 32'(db_estado), 0);
        tick(4);

        // bounce then stable hold
        repeat (3) begin
            botoes = 4'b0010;
            tick(2);
            botoes = 4'b0000;
            tick(2);
        end
        botoes = 4'b0010;
        esperado(4'b0010, 1'b0);
        tick(10);
        botoes = 4'b0000;
        tick(10);

        // long hold produces no repeat
        botoes = 4'b0100;
        esperado(4'b0100, 1'b0);
        tick(40);
        chk("t4_jogada", 32'(jogada), 32'h4);
        chk("t4_estado", 32'(db_estado), 3);
        botoes = 4'b0000;
        tick(10);

        // two buttons at once
        botoes = 4'b0110;
        esperado(4'b0110, 1'b1);
        tick(10);
        chk("t5_mult_mantido", 32'(multipla), 1);
        botoes = 4'b0000;
        tick(10);

        // held while disabled must not count when enabled
        habilita = 1'b0;
        botoes   = 4'b1000;
        tick(5);
        habilita = 1'b1;
        tick(10);
        chk("t6_ocioso", 32'(db_estado), 0);
        botoes = 4'b0000;
        tick(6);
        botoes = 4'b1000;
        esperado(4'b1000, 1'b0);
        tick(10);
        botoes = 4'b0000;
        tick(10);

        // reset in the middle of filtering
        botoes = 4'b0001;
        tick(4);
        chk("t7_filtra", 32'(db_estado), 1);
        reset  = 1'b1;
        botoes = 4'b0000;
        tick(1);
        chk("t7_estado", 32'(db_estado), 0);
        chk("t7_tem", 32'(tem_jogada), 0);
        chk("t7_jogada", 32'(jogada), 0);
        chk("t7_mult", 32'(multipla), 0);
        reset = 1'b0;
        tick(15);

        chk("fila_vazia", fila.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
